// File: rtl/trap_ctrl.sv
// trap_ctrl: M-mode trap sequencer, commits exception / MRET / interrupt CSR updates and redirects the PC.
// Interrupt support is built only when TRAP_CTRL_IRQ_EN is defined.
module trap_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_tval_i,
  input  logic        mret_i,
  input  logic        meip_i,
  input  logic        mtip_i,
  input  logic        msip_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mcause_i,
  input  logic [31:0] mtval_i,
  input  logic [31:0] exc_ret_addr_i,
  output logic        we_exc_o,
  output logic        is_int_o,
  output logic [31:0] mcause_d_o,
  output logic [31:0] mepc_d_o,
  output logic [31:0] mtval_d_o,
  output logic [31:0] mstatus_d_o,
  output logic [31:0] mip_d_o,
  output logic        sel_exc_nret_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COMMIT   = 2'd1,
    REDIRECT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    EV_EXC  = 2'd0,
    EV_MRET = 2'd1,
    EV_INT  = 2'd2
  } ev_e;

  state_e      state_q, state_d;
  ev_e         ev_q, ev_d;
  logic [3:0]  code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tval_q;
  logic [31:0] rpc_q;

  logic        irq_pend;
  logic [3:0]  irq_code;
  logic        take;
  logic        accept;
  logic        mret_sel;
  logic        int_sel;
  logic [31:0] trap_status;
  logic [31:0] mret_status;

`ifdef TRAP_CTRL_IRQ_EN
  logic       mei, msi, mti;
  logic [2:0] lines_q;
  logic       unused_mie;

  assign mei = meip_i & mie_i[11];
  assign msi = msip_i & mie_i[3];
  assign mti = mtip_i & mie_i[7];
  assign irq_pend = mstatus_i[3] & (mei | msi | mti);
  assign unused_mie = ^{mie_i[31:12], mie_i[10:8],
                        mie_i[6:4], mie_i[2:0]};

  always_comb begin
    irq_code = 4'd7;
    if (mei)      irq_code = 4'd11;
    else if (msi) irq_code = 4'd3;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lines_q <= 3'b000;
    end else if (accept) begin
      lines_q <= int_sel ? {meip_i, mtip_i, msip_i} : 3'b000;
    end
  end
`else
  logic unused_irq;

  assign irq_pend   = 1'b0;
  assign irq_code   = 4'd0;
  assign unused_irq = ^{meip_i, mtip_i, msip_i, mie_i};
`endif

  assign take     = exc_valid_i | mret_i | irq_pend;
  assign accept   = (state_q == IDLE) & take;
  assign mret_sel = mret_i & ~exc_valid_i;
  assign int_sel  = irq_pend & ~exc_valid_i & ~mret_i;

  // MPIE<=MIE, MIE<=0, MPP<=M on trap entry
  assign trap_status = {mstatus_i[31:13], 2'b11, mstatus_i[10:8],
                        mstatus_i[3], mstatus_i[6:4], 1'b0,
                        mstatus_i[2:0]};
  assign mret_status = {mstatus_i[31:13], 2'b11, mstatus_i[10:8],
                        1'b1, mstatus_i[6:4], mstatus_i[7],
                        mstatus_i[2:0]};

  always_comb begin
    ev_d   = EV_EXC;
    code_d = exc_code_i;
    pc_d   = {exc_pc_i[31:2], 2'b00};
    unique case (1'b1)
      exc_valid_i: ;
      mret_sel: ev_d = EV_MRET;
      int_sel: begin
        ev_d   = EV_INT;
        code_d = irq_code;
        pc_d   = exc_pc_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (take) state_d = COMMIT;
      COMMIT:   state_d = REDIRECT;
      REDIRECT: if (redirect_ready_i) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ev_q   <= EV_EXC;
      code_q <= 4'd0;
      pc_q   <= 32'd0;
      tval_q <= 32'd0;
      rpc_q  <= 32'd0;
    end else begin
      if (accept) begin
        ev_q   <= ev_d;
        code_q <= code_d;
        pc_q   <= pc_d;
        tval_q <= exc_tval_i;
      end
      if (state_q == COMMIT) rpc_q <= exc_ret_addr_i;
    end
  end

  always_comb begin
    we_exc_o         = 1'b0;
    is_int_o         = 1'b0;
    mcause_d_o       = 32'd0;
    mepc_d_o         = 32'd0;
    mtval_d_o        = 32'd0;
    mstatus_d_o      = 32'd0;
    mip_d_o          = 32'd0;
    sel_exc_nret_o   = 1'b0;
    stall_o          = 1'b0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'd0;
    unique case (state_q)
      COMMIT: begin
        we_exc_o       = 1'b1;
        flush_o        = 1'b1;
        stall_o        = 1'b1;
        sel_exc_nret_o = (ev_q == EV_MRET);
        unique case (ev_q)
          EV_MRET: begin
            mstatus_d_o = mret_status;
            mepc_d_o    = mepc_i;
            mcause_d_o  = mcause_i;
            mtval_d_o   = mtval_i;
          end
`ifdef TRAP_CTRL_IRQ_EN
          EV_INT: begin
            is_int_o    = 1'b1;
            mcause_d_o  = {1'b1, 27'd0, code_q};
            mepc_d_o    = pc_q;
            mstatus_d_o = trap_status;
            mip_d_o     = {20'd0, lines_q[2], 3'd0,
                           lines_q[1], 3'd0,
                           lines_q[0], 3'd0};
          end
`endif
          default: begin
            mcause_d_o  = {28'd0, code_q};
            mepc_d_o    = pc_q;
            mtval_d_o   = tval_q;
            mstatus_d_o = trap_status;
          end
        endcase
      end
      REDIRECT: begin
        stall_o          = 1'b1;
        redirect_valid_o = 1'b1;
        redirect_pc_o    = rpc_q;
        sel_exc_nret_o   = (ev_q == EV_MRET);
      end
      default: ;
    endcase
  end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have port clk_i  in  1  single clock, all state on rising edge.
REQ-002 SHALL have port rst_ni  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports exc_valid_i in 1 and exc_code_i in 4, which flag a synchronous exception and give its cause. exc_pc_i and exc_tval_i, in 32 each, carry the faulting PC and tval.
REQ-004 SHALL have port mret_i  in  1  MRET retiring.
REQ-005 SHALL have ports meip_i, mtip_i, msip_i  in  1 each  level interrupt lines.
REQ-006 SHALL have ports mstatus_i, mie_i, mepc_i, mcause_i, mtval_i  in  32 each  current CSR values.
REQ-007 SHALL have port exc_ret_addr_i  in  32  target from CSR block (mepc if sel_exc_nret_o=1, else mtvec).
REQ-008 SHALL have ports we_exc_o and is_int_o, out 1 each, which are the CSR write strobes.
REQ-009 SHALL have ports mcause_d_o, mepc_d_o, mtval_d_o, mstatus_d_o, mip_d_o  out  32 each  CSR write data.
REQ-010 SHALL have port sel_exc_nret_o  out  1  return-address select to CSR block.
REQ-011 SHALL have ports stall_o and flush_o, out 1 each, for pipeline control.
REQ-012 SHALL have ports redirect_valid_o out 1 and redirect_pc_o out 32 with input redirect_ready_i 1, forming a PC redirect handshake.

Function
REQ-013 SHALL implement FSM IDLE -> COMMIT -> REDIRECT -> IDLE; COMMIT lasts exactly 1 cycle.
REQ-014 In IDLE, event priority SHALL be: exc_valid_i > mret_i > pending interrupt; the winner is latched and the FSM goes to COMMIT next cycle.
REQ-015 An interrupt SHALL be pending when mstatus_i[3]=1 and (meip_i&mie_i[11] | msip_i&mie_i[3] | mtip_i&mie_i[7]); priority among them is MEI > MSI > MTI.
REQ-016 Exception commit SHALL set mcause_d_o={28'b0,exc_code}, mepc_d_o={exc_pc[31:2],2'b00}, mtval_d_o=exc_tval, and mstatus_d_o=mstatus with MPIE(7)<=MIE(3), MIE<=0, MPP(12:11)<=2'b11.
REQ-017 Interrupt commit SHALL set mcause_d_o to 0x8000000B, 0x80000003 or 0x80000007 and mepc_d_o=exc_pc_i latched at accept, with the same mstatus update and mtval_d_o=0. It SHALL also set is_int_o=1 and mip_d_o to the latched lines at bits 11/7/3, with other bits 0.
REQ-018 MRET commit SHALL set mstatus_d_o=mstatus with MIE<=MPIE, MPIE<=1 and MPP<=2'b11; mepc/mcause/mtval_d_o pass through mepc_i/mcause_i/mtval_i.
REQ-019 we_exc_o SHALL pulse exactly one cycle in COMMIT for every accepted event; flush_o SHALL pulse in the same cycle.
REQ-020 sel_exc_nret_o SHALL be 1 from COMMIT through REDIRECT for MRET and 0 otherwise.
REQ-021 In REDIRECT, redirect_valid_o SHALL be 1 and redirect_pc_o SHALL equal exc_ret_addr_i sampled at COMMIT, held stable until redirect_ready_i=1. The FSM then returns to IDLE on the next edge.
REQ-022 stall_o SHALL be 1 in COMMIT and REDIRECT; latency is event cycle N -> we_exc_o at N+1 -> redirect_valid_o at N+2.
REQ-023 Events arriving outside IDLE SHALL be ignored; level interrupts still pending re-evaluate in IDLE.
REQ-024 Same-cycle handshake completion and new event SHALL not overlap: the new event is accepted only in the following IDLE cycle.

Reset
REQ-025 Asserting rst_ni=0 SHALL immediately force IDLE; every output and latched register SHALL go to 0.
REQ-026 Reset mid-operation SHALL abandon any commit/redirect with no we_exc_o pulse after release.

Configuration
REQ-027 Macro TRAP_CTRL_IRQ_EN SHALL control interrupt support.
REQ-028 When TRAP_CTRL_IRQ_EN is defined, interrupt handling SHALL follow REQ-015/017.
REQ-029 When TRAP_CTRL_IRQ_EN is undefined, meip/mtip/msip SHALL be ignored and is_int_o and mip_d_o SHALL be tied to 0.

Verification
REQ-030 Bench SHALL drive exc_valid_i with code 2, pc 0x100 and mstatus 0x8, then expect we_exc_o at +1 with mcause 0x2, mepc 0x100 and mstatus_d 0x1880. It SHALL then expect redirect to the mtvec value.
REQ-031 Bench SHALL drive mret_i with mstatus 0x1880, then expect mstatus_d 0x1888 and sel_exc_nret_o=1. redirect_pc_o SHALL equal mepc_i.
REQ-032 Bench SHALL drive meip_i and mtip_i with mie 0x880 and mstatus 0x8. It SHALL expect mcause 0x8000000B, is_int_o=1 and mip_d 0x880.
REQ-033 Bench SHALL drive exc_valid_i, mret_i and meip_i in the same cycle, then expect an exception commit only.
REQ-034 Bench SHALL hold redirect_ready_i=0 for 5 cycles, then expect redirect_valid_o and redirect_pc_o stable and new events ignored.
REQ-035 Bench SHALL drop rst_ni in COMMIT, then expect all outputs 0 asynchronously and IDLE after release.
